instr_fetch_unit: RTL and testbench

//  Upstream feeder for the processor control FSM. Fetches 16-bit instructions from a

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads 16-bit instructions from a synchronous program memory,
// issues each to the control FSM with Run until Done, consumes HALT, and guards EXEC with a watchdog.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              Rest,
  input  logic              start,
  input  logic              Done,
  input  logic [15:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [15:0]       instruction,
  output logic              Run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W-1:0] StartPc = ADDR_W'(START_ADDR);
  localparam logic [LatW-1:0]   LatInit = LatW'(MEM_LAT);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       instr_q, instr_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic              fault_q, fault_d;
  logic              rd_q, rd_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    lat_d   = lat_q;
    wd_d    = wd_q;
    fault_d = fault_q;
    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = StartPc;
          addr_d  = StartPc;
          fault_d = 1'b0;
        end
      end
      StFetch: begin
        state_d = StWait;
        lat_d   = LatInit;
      end
      StWait: begin
        lat_d = lat_q - 1'b1;
        // Counter reaching 1 marks the cycle in which mem_rdata is valid.
        if (lat_q == LatW'(1)) begin
          instr_d = mem_rdata;
          wd_d    = '0;
          state_d = (mem_rdata[15:13] == 3'b111) ? StHalt : StExec;
        end
      end
      StExec: begin
        wd_d = wd_q + 1'b1;
        if (Done) begin
          state_d = StFetch;
          pc_d    = pc_q + 1'b1;
          addr_d  = pc_q + 1'b1;
        end else if ((TIMEOUT != 0) && ((32'(wd_q) + 32'd1) == TIMEOUT)) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the decoded next state.
    rd_d     = (state_d == StFetch);
    run_d    = (state_d == StExec);
    busy_d   = (state_d == StFetch) || (state_d == StWait) || (state_d == StExec);
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clock) begin
    if (Rest) begin
      state_q  <= StIdle;
      pc_q     <= StartPc;
      addr_q   <= '0;
      instr_q  <= 16'h0000;
      lat_q    <= '0;
      wd_q     <= '0;
      fault_q  <= 1'b0;
      rd_q     <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      lat_q    <= lat_d;
      wd_q     <= wd_d;
      fault_q  <= fault_d;
      rd_q     <= rd_d;
      run_q    <= run_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_rd      = rd_q;
  assign instruction = instr_q;
  assign Run         = run_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table for issue/halt/restart,
// plus hand sequences for wrap, watchdog, longer memory latency and mid-EXEC reset.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance 0: defaults (START_ADDR=0, MEM_LAT=1, TIMEOUT=16)
  logic        rest0, start0, done0, rd0, run0, busy0, halted0, fault0;
  logic [15:0] rdata0, instr0;
  logic [7:0]  addr0, pc0;
  logic [15:0] mem0 [256];

  // Instance 1: START_ADDR=255
  logic        rest1, start1, done1, rd1, run1, busy1, halted1, fault1;
  logic [15:0] rdata1, instr1;
  logic [7:0]  addr1, pc1;
  logic [15:0] mem1 [256];

  // Instance 2: MEM_LAT=3
  logic        rest2, start2, done2, rd2, run2, busy2, halted2, fault2;
  logic [15:0] rdata2, instr2, pipe2_a, pipe2_b;
  logic [7:0]  addr2, pc2;
  logic [15:0] mem2 [256];

  instr_fetch_unit #(.ADDR_W(8), .START_ADDR(0), .MEM_LAT(1), .TIMEOUT(16)) u0 (
    .clock(clk), .Rest(rest0), .start(start0), .Done(done0), .mem_rdata(rdata0),
    .mem_addr(addr0), .mem_rd(rd0), .instruction(instr0), .Run(run0), .pc(pc0),
    .busy(busy0), .halted(halted0), .fault(fault0));

  instr_fetch_unit #(.ADDR_W(8), .START_ADDR(255), .MEM_LAT(1), .TIMEOUT(16)) u1 (
    .clock(clk), .Rest(rest1), .start(start1), .Done(done1), .mem_rdata(rdata1),
    .mem_addr(addr1), .mem_rd(rd1), .instruction(instr1), .Run(run1), .pc(pc1),
    .busy(busy1), .halted(halted1), .fault(fault1));

  instr_fetch_unit #(.ADDR_W(8), .START_ADDR(0), .MEM_LAT(3), .TIMEOUT(16)) u2 (
    .clock(clk), .Rest(rest2), .start(start2), .Done(done2), .mem_rdata(rdata2),
    .mem_addr(addr2), .mem_rd(rd2), .instruction(instr2), .Run(run2), .pc(pc2),
    .busy(busy2), .halted(halted2), .fault(fault2));

  always @(posedge clk) begin
    if (rd0) rdata0 <= mem0[addr0];
    if (rd1) rdata1 <= mem1[addr1];
    pipe2_a <= mem2[addr2];
    pipe2_b <= pipe2_a;
    rdata2  <= pipe2_b;
  end

  typedef struct {
    logic        st;
    logic        dn;
    logic        rn;
    logic        rd;
    logic [7:0]  addr;
    logic [7:0]  pc;
    logic [15:0] ins;
    logic        bz;
    logic        hl;
    logic        ft;
  } vec_t;

  vec_t vecs [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic dn, input logic rn, input logic rd,
                              input logic [7:0] addr, input logic [7:0] pc, input logic [15:0] ins,
                              input logic bz, input logic hl, input logic ft);
    vec_t v;
    v.st = st; v.dn = dn; v.rn = rn; v.rd = rd; v.addr = addr; v.pc = pc;
    v.ins = ins; v.bz = bz; v.hl = hl; v.ft = ft;
    return v;
  endfunction

  initial begin
    {rest0, start0, done0} = 3'b100;
    {rest1, start1, done1} = 3'b100;
    {rest2, start2, done2} = 3'b100;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    mem0[0]   = 16'h4203;
    mem0[1]   = 16'h1234;
    mem0[2]   = 16'hE000;
    mem1[255] = 16'h0001;
    mem1[0]   = 16'h0002;
    mem2[0]   = 16'h4203;

    // Inputs applied during cycle k; expected outputs in cycle k+1.
    vecs[0]  = mk(1, 0, 0, 1, 8'h00, 8'h00, 16'h0000, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 8'h00, 8'h00, 16'h0000, 1, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[7]  = mk(0, 1, 0, 1, 8'h01, 8'h01, 16'h4203, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 8'h01, 8'h01, 16'h4203, 1, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 8'h01, 8'h01, 16'h1234, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 1, 8'h02, 8'h02, 16'h1234, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 8'h02, 8'h02, 16'h1234, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 8'h02, 8'h02, 16'hE000, 0, 1, 0);
    vecs[13] = mk(0, 1, 0, 0, 8'h02, 8'h02, 16'hE000, 0, 1, 0);
    vecs[14] = mk(1, 0, 0, 1, 8'h00, 8'h00, 16'hE000, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 8'h00, 8'h00, 16'hE000, 1, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);
    vecs[17] = mk(1, 0, 1, 0, 8'h00, 8'h00, 16'h4203, 1, 0, 0);

    step();
    {rest0, rest1, rest2} = 3'b000;
    chk("reset0", {run0, rd0, addr0, pc0, instr0, busy0, halted0, fault0}, 64'h0);
    chk("reset1_pc", {56'h0, pc1}, 64'hFF);

    // Issue, back-to-back issue, HALT, ignored Done/start, restart.
    for (int k = 0; k < 18; k++) begin
      start0 = vecs[k].st;
      done0  = vecs[k].dn;
      step();
      chk($sformatf("vec%0d", k),
          {run0, rd0, addr0, pc0, instr0, busy0, halted0, fault0},
          {vecs[k].rn, vecs[k].rd, vecs[k].addr, vecs[k].pc, vecs[k].ins,
           vecs[k].bz, vecs[k].hl, vecs[k].ft});
    end
    start0 = 1'b0;
    done0  = 1'b0;

    // Watchdog expiry with Done held low.
    rest0 = 1'b1; step(); rest0 = 1'b0;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (int n = 0; n < 20 && !run0; n++) step();
    chk("wd_wait_run", {63'h0, run0}, 64'h1);
    repeat (15) step();
    chk("wd_run_at_16", {61'h0, run0, fault0, halted0}, 64'h4);
    step();
    chk("wd_fault", {53'h0, fault0, halted0, run0, pc0}, {53'h0, 3'b110, 8'h00});
    start0 = 1'b1; step(); start0 = 1'b0;
    chk("wd_clear", {62'h0, fault0, halted0}, 64'h0);
    for (int n = 0; n < 20 && !run0; n++) step();
    chk("wd_wait_run2", {63'h0, run0}, 64'h1);
    repeat (15) step();
    done0 = 1'b1; step(); done0 = 1'b0;
    chk("wd_done_wins", {52'h0, fault0, halted0, run0, rd0, pc0}, {52'h0, 4'b0001, 8'h01});

    // PC wrap from START_ADDR=255.
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int n = 0; n < 20 && !run1; n++) step();
    chk("wrap_issue", {39'h0, run1, pc1, instr1}, {39'h0, 1'b1, 8'hFF, 16'h0001});
    done1 = 1'b1; step(); done1 = 1'b0;
    chk("wrap_pc", {47'h0, rd1, pc1, addr1}, {47'h0, 1'b1, 8'h00, 8'h00});
    step(); step();
    chk("wrap_next", {47'h0, run1, instr1}, {47'h0, 1'b1, 16'h0002});

    // MEM_LAT=3 latency, then reset during EXEC and a stray Done.
    start2 = 1'b1; step(); start2 = 1'b0;
    chk("lat3_fetch", {55'h0, rd2, addr2}, {55'h0, 1'b1, 8'h00});
    step(); step(); step();
    chk("lat3_not_yet", {63'h0, run2}, 64'h0);
    step();
    chk("lat3_run", {47'h0, run2, instr2}, {47'h0, 1'b1, 16'h4203});
    rest2 = 1'b1; step(); rest2 = 1'b0;
    chk("lat3_reset", {run2, rd2, addr2, pc2, instr2, busy2, halted2, fault2}, 64'h0);
    done2 = 1'b1; step(); done2 = 1'b0;
    chk("lat3_stray_done", {60'h0, busy2, run2, rd2, halted2}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
